counter_prog: RTL
=================

Name: counter_prog

Overview:
- Parametrised successor of the team's 8-bit enable/clear counter.
- Adds the following over that counter:
  - configurable width;
  - up/down direction;
  - synchronous parallel load;
  - programmable terminal value (modulo);
  - wrap or saturate mode;
  - registered wrap pulse;
  - sticky overflow status.
- Used as a general event/timer counter in peripheral and test blocks.

Parameters:
- WIDTH, 8: counter width in bits (2..32).
- SAT_MODE, 0: 0 = wrap at terminal, 1 = saturate (hold) at terminal.
- RST_VAL, 0: count value after reset and after count_clr. Must be <= 2^WIDTH-1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- count_en  in  1  count enable.
- count_clr  in  1  synchronous clear to RST_VAL.
- count_dir  in  1  1 = count up, 0 = count down.
- load_en  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- term_val  in  WIDTH  programmable upper terminal value, held static while counting.
- sticky_clr  in  1  clears ovf_sticky.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal count, combinational.
- wrap  out  1  one-cycle registered pulse.
- ovf_sticky  out  1  sticky overflow/underflow status (registered).

Behaviour:
- Reset (rst_n=0, asynchronous): count=RST_VAL, wrap=0, ovf_sticky=0. tc follows its equation from the reset-state count.
- Per-edge priority: count_clr > load_en > count_en > hold.
- count_clr=1: count<=RST_VAL. No wrap pulse. ovf_sticky unchanged.
- load_en=1 (clr=0): count<=load_val, any value, even above term_val. No wrap pulse.
- Up terminal: count_dir=1 and count>=term_val.
- Down terminal: count_dir=0 and count==0.
- tc = count_en & ~count_clr & ~load_en & (up terminal | down terminal). Same-cycle indication, matching the legacy overflow semantic: high while sitting at terminal with enable.
- Enabled, not at terminal: up gives count+1, down gives count-1.
- Enabled, at terminal, SAT_MODE=0:
  - up: count<=0;
  - down: count<=term_val.
- Enabled, at terminal, SAT_MODE=1: count holds.
- wrap: registered copy of tc; high exactly the cycle after a terminal event, in both modes. Consecutive terminal cycles (saturate, or term_val=0 wrapping every cycle) keep wrap high continuously.
- ovf_sticky: set on any edge where tc=1. Cleared by sticky_clr. Set wins if both occur on the same edge.
- term_val=0, up, wrap mode: count stays 0 and tc=1 on every enabled cycle.
- term_val=2^WIDTH-1 gives a full-range binary counter, equivalent to the legacy block.
- Direction change mid-count takes effect on the next edge with no glitch.
- No arithmetic overflow beyond WIDTH bits is possible: all next values are explicitly 0, term_val, count±1 or hold.
- Reset asserted mid-count: immediate return to reset values. Counting resumes on the first edge with rst_n=1 and count_en=1.

Test Plan (WIDTH=8, SAT_MODE=0, RST_VAL=0 unless noted):
1. Reset release, en=0 for 5 cycles -> count=8'h00, tc=0, wrap=0, ovf_sticky=0.
2. term_val=8'hFF, up, en=1 for 255 edges -> count=8'hFF and tc=1. Next edge -> count=8'h00, wrap=1 for one cycle, ovf_sticky=1. 10 more edges -> count=8'h0A.
3. term_val=8'h09, down, load_val=8'h02 with load for 1 edge, then en -> count 02,01,00,09,08. wrap pulses one cycle after the 00 cycle.
4. Priority: en=1, load_en=1 (load_val=8'h55), count_clr=1 on the same edge -> count=8'h00. Next edge with clr=0 -> count=8'h55, no wrap.
5. SAT_MODE=1, term_val=8'h05, up, en for 8 edges -> count holds 8'h05, tc=1 and wrap=1 continuously. sticky_clr asserted together with tc=1 -> ovf_sticky stays 1.
6. Mid-count reset: count=8'h33, pulse rst_n low for 3 ns between edges -> count=8'h00 immediately, wrap=0, ovf_sticky=0. Counting resumes from 8'h00.

Source files
------------

// File: rtl/counter_prog.sv
// Programmable up/down event counter: parallel load, programmable terminal value,
// wrap or saturate mode, registered wrap pulse and sticky overflow status.
module counter_prog #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SAT_MODE = 0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic             count_clr,
    input  logic             count_dir,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    input  logic             sticky_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    logic             up_term;
    logic             down_term;
    logic             at_term;
    logic [WIDTH-1:0] count_nxt;

    // Up terminal uses >= so a count loaded above term_val still terminates.
    assign up_term   = count_dir && (count >= term_val);
    assign down_term = !count_dir && (count == '0);
    assign at_term   = up_term || down_term;

    assign tc = count_en && !count_clr && !load_en && at_term;

    always_comb begin
        count_nxt = count;
        if (count_clr) begin
            count_nxt = RESET_COUNT;
        end else if (load_en) begin
            count_nxt = load_val;
        end else if (count_en) begin
            if (at_term) begin
                if (SAT_MODE == 0) begin
                    count_nxt = count_dir ? '0 : term_val;
                end
            end else begin
                count_nxt = count_dir ? (count + ONE) : (count - ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= RESET_COUNT;
            wrap       <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= tc;
            // Setting beats clearing when both land on the same edge.
            if (tc) begin
                ovf_sticky <= 1'b1;
            end else if (sticky_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule
